// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types: the result record carried through each holding slot
// and the hard-wired-zero integer register index.
package wb_arbiter_pkg;

    localparam int         WB_DATA_W = 32;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef struct packed {
        logic [4:0]           dest;
        logic                 freg;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Requester handshakes plus the shared register-file write port.
// The slave modport is the arbiter; the master modport is the producer/register-file side.
interface wb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]             in_valid;
    logic [NREQ-1:0]             in_ready;
    logic [NREQ-1:0][4:0]        in_dest;
    logic [NREQ-1:0]             in_freg;
    logic [NREQ-1:0][DATA_W-1:0] in_data;
    logic                        reg_w_enable;
    logic                        freg_w_enable;
    logic [4:0]                  reg_w_dest;
    logic [DATA_W-1:0]           reg_w_data;
    logic [NREQ-1:0]             grant;
    logic                        idle;

    modport slave (
        input  in_valid, in_dest, in_freg, in_data,
        output in_ready, reg_w_enable, freg_w_enable, reg_w_dest, reg_w_data, grant, idle
    );

    modport master (
        output in_valid, in_dest, in_freg, in_data,
        input  in_ready, reg_w_enable, freg_w_enable, reg_w_dest, reg_w_data, grant, idle
    );
endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin select: first candidate after last_i (mod N) wins.
// Returns a one-hot grant, zero when no candidate is set.
module rr_pick #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] cand_i,
    input  logic [W-1:0] last_i,
    output logic [N-1:0] grant_o
);
    logic         found;
    logic [W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(last_i) + k) % N);
            if (!found && cand_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding slot per producer, round-robin onto the shared RF write port.
// Define WB_BYPASS_EN to let an empty slot's incoming result compete and write in the same cycle.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic          clk,
    input  logic          rstn,
    wb_arbiter_if.slave   wb
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_req_t [NREQ-1:0] slot_q, slot_d;
    logic    [NREQ-1:0] vld_q, vld_d;
    logic    [IW-1:0]   last_q, last_d;

    wb_req_t [NREQ-1:0] in_req;
    logic    [NREQ-1:0] vld_eff, cand, gnt, byp, rdy;
    wb_req_t            win_req;
    logic               win;
    logic    [IW-1:0]   win_idx;

    // Holding rstn low hides slot contents so nothing is written during reset.
    assign vld_eff = vld_q & {NREQ{rstn}};

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            in_req[i].dest = wb.in_dest[i];
            in_req[i].freg = wb.in_freg[i];
            in_req[i].data = wb.in_data[i];
        end
    end

`ifdef WB_BYPASS_EN
    assign cand = (vld_eff | wb.in_valid) & {NREQ{rstn}};
    assign byp  = gnt & ~vld_eff;
`else
    assign cand = vld_eff;
    assign byp  = '0;
`endif

    rr_pick #(.N(NREQ), .W(IW)) u_pick (
        .cand_i  (cand),
        .last_i  (last_q),
        .grant_o (gnt)
    );

    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        win_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win     = 1'b1;
                win_idx = IW'(i);
`ifdef WB_BYPASS_EN
                win_req = vld_eff[i] ? slot_q[i] : in_req[i];
`else
                win_req = slot_q[i];
`endif
            end
        end
    end

    assign rdy              = ~vld_eff | gnt;
    assign wb.in_ready      = rdy;
    assign wb.grant         = gnt;
    assign wb.reg_w_enable  = win && !win_req.freg && (win_req.dest != REG_ZERO);
    assign wb.freg_w_enable = win && win_req.freg;
    assign wb.reg_w_dest    = win_req.dest;
    assign wb.reg_w_data    = win_req.data;
    assign wb.idle          = ~(|vld_eff) && ~(|wb.in_valid);

    // A granted slot may be refilled in the same cycle; a bypassed result never lands in it.
    always_comb begin
        slot_d = slot_q;
        vld_d  = vld_q;
        last_d = last_q;
        for (int i = 0; i < NREQ; i++) begin
            if (wb.in_valid[i] && rdy[i] && !byp[i]) begin
                slot_d[i] = in_req[i];
                vld_d[i]  = 1'b1;
            end else if (gnt[i]) begin
                vld_d[i]  = 1'b0;
            end
        end
        if (win) last_d = win_idx;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q  <= '0;
            last_q <= IW'(NREQ - 1);
            slot_q <= '0;
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            slot_q <= slot_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Random + directed bench for wb_arbiter: a queue-per-requester reference model predicts
// each cycle's write; a separate monitor pops the prediction and compares it to the port.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = 32;

    typedef struct {
        logic [2:0]  gnt;
        logic        wen;
        logic        fwen;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) bus ();
    wb_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (.clk(clk), .rstn(rstn), .wb(bus));

    int      errors = 0;
    int      checks = 0;
    exp_t    exp_q[$];
    wb_req_t pend[NREQ][$];
    int      mlast = NREQ - 1;

    logic        hold[NREQ];
    logic [4:0]  hd[NREQ];
    logic        hf[NREQ];
    logic [31:0] hx[NREQ];

    task automatic present(input int i, input logic [4:0] d, input logic f, input logic [31:0] x);
        hold[i] = 1'b1; hd[i] = d; hf[i] = f; hx[i] = x;
    endtask

    task automatic present_rand(input int i);
        present(i, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
    endtask

    // One clock cycle: drive, predict, check handshake, then advance the model at the edge.
    task automatic tick(input logic r);
        logic [2:0] cand, rdy, vin;
        int         w, idx;
        logic       byp, empty;
        wb_req_t    req;
        exp_t       e;
        @(negedge clk);
        rstn = r;
        for (int i = 0; i < NREQ; i++) begin
            bus.in_valid[i] = hold[i];
            bus.in_dest[i]  = hd[i];
            bus.in_freg[i]  = hf[i];
            bus.in_data[i]  = hx[i];
            vin[i]          = hold[i];
        end
        #1;
        cand = '0; w = -1; byp = 1'b0; empty = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i].size() != 0) empty = 1'b0;
            if (r) begin
                if (pend[i].size() != 0) cand[i] = 1'b1;
`ifdef WB_BYPASS_EN
                else if (hold[i]) cand[i] = 1'b1;
`endif
            end
        end
        if (!r) empty = 1'b1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (mlast + k) % NREQ;
            if (w < 0 && cand[idx]) w = idx;
        end
        for (int i = 0; i < NREQ; i++)
            rdy[i] = !r || pend[i].size() == 0 || w == i;
        checks++;
        if (bus.in_ready !== rdy) begin
            errors++;
            $display("FAIL in_ready: got %b want %b at %0t", bus.in_ready, rdy, $time);
        end
        checks++;
        if (bus.idle !== (empty && vin == 3'b000)) begin
            errors++;
            $display("FAIL idle: got %b want %b at %0t", bus.idle, (empty && vin == 3'b000), $time);
        end
        e = '{gnt: 3'b000, wen: 1'b0, fwen: 1'b0, dest: 5'd0, data: 32'd0};
        if (w >= 0) begin
            if (pend[w].size() != 0) req = pend[w][0];
            else begin
                req = '{dest: hd[w], freg: hf[w], data: hx[w]};
                byp = 1'b1;
            end
            e.gnt  = 3'(1 << w);
            e.fwen = req.freg;
            e.wen  = !req.freg && req.dest != 5'd0;
            e.dest = req.dest;
            e.data = req.data;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < NREQ; i++) begin
                pend[i].delete();
                hold[i] = 1'b0;
            end
            mlast = NREQ - 1;
        end else begin
            if (w >= 0 && !byp) void'(pend[w].pop_front());
            for (int i = 0; i < NREQ; i++) begin
                if (hold[i] && rdy[i]) begin
                    if (!(byp && w == i)) pend[i].push_back('{dest: hd[i], freg: hf[i], data: hx[i]});
                    hold[i] = 1'b0;
                end
            end
            if (w >= 0) mlast = w;
        end
    endtask

    // Monitor: every cycle the port presents a write (or no write); compare with the prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.grant !== e.gnt || bus.reg_w_enable !== e.wen || bus.freg_w_enable !== e.fwen ||
                    bus.reg_w_dest !== e.dest || bus.reg_w_data !== e.data) begin
                    errors++;
                    $display("FAIL wb_port: got g=%b we=%b fwe=%b d=%0d x=%h want g=%b we=%b fwe=%b d=%0d x=%h at %0t",
                             bus.grant, bus.reg_w_enable, bus.freg_w_enable, bus.reg_w_dest, bus.reg_w_data,
                             e.gnt, e.wen, e.fwen, e.dest, e.data, $time);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            hold[i] = 1'b0; hd[i] = '0; hf[i] = 1'b0; hx[i] = '0;
        end
        bus.in_valid = '0; bus.in_dest = '0; bus.in_freg = '0; bus.in_data = '0;

        repeat (3) tick(1'b0);
        repeat (2) tick(1'b1);

        // ALU x5 alone
        present(0, 5'd5, 1'b0, 32'h0000_1234);
        repeat (3) tick(1'b1);

        // all three continuously valid: grants rotate
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NREQ; i++) if (!hold[i]) present_rand(i);
            tick(1'b1);
        end
        repeat (4) tick(1'b1);

        // FPU f0 and ALU x0
        present(2, 5'd0, 1'b1, 32'h3F80_0000);
        present(0, 5'd0, 1'b0, 32'h0000_DEAD);
        repeat (4) tick(1'b1);

        // load slot held while ALU keeps requesting
        present(1, 5'd9, 1'b0, 32'hCAFE_0001);
        for (int c = 0; c < 6; c++) begin
            if (!hold[0]) present_rand(0);
            tick(1'b1);
        end
        repeat (3) tick(1'b1);

        // fill all slots, reset, then ALU must win first
        for (int i = 0; i < NREQ; i++) present_rand(i);
        tick(1'b1);
        tick(1'b0);
        for (int i = 0; i < NREQ; i++) present_rand(i);
        repeat (5) tick(1'b1);

        // random traffic with an occasional reset
        for (int c = 0; c < 400; c++) begin
            int pct;
            pct = (c < 200) ? 40 : 90;
            for (int i = 0; i < NREQ; i++)
                if (!hold[i] && $urandom_range(0, 99) < pct) present_rand(i);
            tick(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
        end
        repeat (4) tick(1'b1);

        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sharing the single register-file write port between the core's result producers: ALU, load unit, FPU. Each requester hands over a result with a valid/ready handshake into a one-entry holding slot. A round-robin grant selects one slot per cycle and drives the write-back port seen by the integer and float register files. Sits between the execute/memory units and the register files and replaces per-unit write-enable muxing.

## Interface
- NREQ, 3, number of requesters (index 0 = ALU, 1 = load, 2 = FPU)
- DATA_W, 32, result width
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low, sampled on rising clk
- in_valid  in  NREQ  requester i presents a result
- in_ready  out  NREQ  requester i's result is taken this cycle
- in_dest  in  NREQ×5  destination register index
- in_freg  in  NREQ  1 = float register file, 0 = integer
- in_data  in  NREQ×DATA_W  result value
- reg_w_enable  out  1  integer register-file write strobe
- freg_w_enable  out  1  float register-file write strobe
- reg_w_dest  out  5  write index, shared by both files
- reg_w_data  out  DATA_W  write value
- grant  out  NREQ  one-hot: slot or bypass written this cycle
- idle  out  1  all slots empty and no in_valid

## Operation
- Each requester owns one slot holding {valid, dest, freg, data}.
- Candidate i = slot i valid. With WB_BYPASS_EN, candidate i also = (slot empty && in_valid[i]).
- Round-robin pointer `last` holds the most recently granted index. Search order is last+1, last+2, … (mod NREQ). The first candidate wins. At most one grant bit is set.
- Write port is combinational from the winner. reg_w_enable = win && !freg && dest != 0. freg_w_enable = win && freg. f0 is writable.
- An integer write to x0 is still granted and consumed, with both strobes low.
- No winner: both strobes 0, grant 0, dest and data 0.
- in_ready[i] = slot empty || grant[i]. A granted slot can be refilled in the same cycle.
- Slot update on accept (in_valid && in_ready, not bypassed): load fields, set valid.
- Slot update on grant without accept: clear valid.
- Bypassed grant: result is written directly, slot stays empty, in_ready = 1.
- `last` updates to the granted index only when grant != 0.
- Ordering: results from one requester are written in accept order. No ordering across requesters. WAW hazards between units are resolved by the issue logic, not here.

## Timing
- Reset, applied synchronously while rstn = 0:
  - all slots invalid, `last` = NREQ-1 (ALU has first priority)
  - outputs: strobes 0, grant 0, dest/data 0, in_ready all 1, idle = !(|in_valid)
- Latency, accept to write:
  - 1 cycle: accepted at edge N, written during cycle N+1
  - 0 cycles when bypassed
- Throughput: one write per cycle total.
- A requester that is continuously valid is granted at least once every NREQ cycles (no starvation).
- Simultaneous grant and refill of the same slot: the new value is visible as a candidate the next cycle.
- A full slot that is not granted holds its value; in_ready = 0 is back-pressure.
- rstn low mid-operation: pending slot contents are discarded, no write that cycle.

## Configuration
- WB_BYPASS_EN defined:
  - an empty slot's incoming request competes directly
  - zero-latency write when granted
  - adds a combinational path from in_* to reg_w_*
- WB_BYPASS_EN undefined:
  - every result passes through its slot
  - write-back outputs depend only on registered state

## Structure
- Shared package (core-wide `types` package): wb_req_t struct {dest[4:0], freg, data[DATA_W-1:0]} and constant REG_ZERO = 5'd0.
- One sub-module: rr_pick. Pure combinational round-robin select taking a candidate vector and `last`, returning a one-hot grant. Reusable by the memory arbiter.

## Test plan
- Reset hold, then release with no traffic: strobes 0, in_ready = 3'b111, idle = 1.
- ALU x5 = 0x1234 alone: write in cycle N+1 with reg_w_enable = 1, dest 5, data 0x00001234, grant 3'b001. With bypass, the write occurs in cycle N.
- All three requesters hold valid for 6 cycles:
  - grants rotate 001, 010, 100, 001, 010, 100
  - each slot is refilled the cycle it is granted
- FPU f0 = 0x3F800000: freg_w_enable = 1, dest 0. ALU x0 = 0xDEAD: grant 3'b001 with both strobes 0, and the slot is freed.
- Load slot full and ALU continuously granted: load in_ready = 0 and data held unchanged until its turn, at most 2 cycles later.
- rstn low with all slots full: the next cycle has no write, all in_ready = 1, `last` = 2.
